// File: rtl/interface_memoria_if.sv
// Bundles the controller/memory-facing signals of the memory interface stage.
// Master = controller plus memory model; slave = interface_memoria.
// Address width follows ADDR_W; data paths are fixed 32-bit words.
interface interface_memoria_if #(
    parameter int ADDR_W = 32
);
    // Request side, driven by the controller
    logic              req;
    logic              esc;
    logic              iou_d;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ula_saida;
    logic [31:0]       dado_esc;
    logic              ir_esc;

    // Memory side
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rd;
    logic              mem_wr;

    // Data and instruction registers, decoded fields, status
    logic [31:0]       mdr;
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic [5:0]        instr_arit;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic              pronto;
    logic              ocupado;
    logic              erro_alinh;

    modport master (
        output req, esc, iou_d, pc, ula_saida, dado_esc, ir_esc, mem_rdata,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, mdr, instr, opcode,
               instr_arit, rs, rt, rd, imm, pronto, ocupado, erro_alinh
    );

    modport slave (
        input  req, esc, iou_d, pc, ula_saida, dado_esc, ir_esc, mem_rdata,
        output mem_addr, mem_wdata, mem_rd, mem_wr, mdr, instr, opcode,
               instr_arit, rs, rt, rd, imm, pronto, ocupado, erro_alinh
    );
endinterface

// File: rtl/interface_memoria.sv
// Memory access stage: one word read/write per request, MDR capture, instruction register.
// Latency: read = LAT_LEITURA+1 cycles to pronto, write = 2, misaligned = 1.
// Backpressure: none; requests arriving while busy (ocupado) are dropped, never queued.
module interface_memoria #(
    parameter int LAT_LEITURA = 2,
    parameter int ADDR_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    interface_memoria_if.slave   mem_if
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        LEITURA   = 2'd1,
        ESCRITA   = 2'd2,
        CONCLUIDO = 2'd3
    } estado_t;

    // Counter value of the last read cycle; MDR samples mem_rdata at its closing edge
    localparam logic [2:0] CNT_FIM = 3'(LAT_LEITURA - 1);

    estado_t           estado_q, estado_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              erro_q, erro_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       mdr_q, mdr_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_sel;

    assign addr_sel = mem_if.iou_d ? mem_if.ula_saida : mem_if.pc;

    // State and datapath registers; reset aborts any access in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            estado_q    <= OCIOSO;
            cnt_q       <= '0;
            erro_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mdr_q       <= '0;
            instr_q     <= '0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            erro_q      <= erro_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mdr_q       <= mdr_d;
            instr_q     <= instr_d;
        end
    end

    // Next-state and datapath update; everything holds unless a transition says otherwise
    always_comb begin
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        erro_d      = erro_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mdr_d       = mdr_q;

        unique case (estado_q)
            OCIOSO: begin
                if (mem_if.req) begin
                    mem_addr_d  = addr_sel;
                    mem_wdata_d = mem_if.dado_esc;
                    cnt_d       = '0;
                    if (addr_sel[1:0] != 2'b00) begin
                        // Misaligned: report straight away, memory is never touched
                        erro_d   = 1'b1;
                        estado_d = CONCLUIDO;
                    end else begin
                        erro_d   = 1'b0;
                        estado_d = mem_if.esc ? ESCRITA : LEITURA;
                    end
                end
            end
            LEITURA: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_FIM) begin
                    mdr_d    = mem_if.mem_rdata;
                    estado_d = CONCLUIDO;
                end
            end
            ESCRITA: begin
                estado_d = CONCLUIDO;
            end
            CONCLUIDO: begin
                erro_d   = 1'b0;
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Instruction register loads from the pre-edge MDR, independent of state
    always_comb begin
        instr_d = instr_q;
        if (mem_if.ir_esc) begin
            instr_d = mdr_q;
        end
    end

    assign mem_if.mem_addr   = mem_addr_q;
    assign mem_if.mem_wdata  = mem_wdata_q;
    assign mem_if.mem_rd     = (estado_q == LEITURA);
    assign mem_if.mem_wr     = (estado_q == ESCRITA);
    assign mem_if.mdr        = mdr_q;
    assign mem_if.instr      = instr_q;
    assign mem_if.opcode     = instr_q[31:26];
    assign mem_if.instr_arit = instr_q[5:0];
    assign mem_if.rs         = instr_q[25:21];
    assign mem_if.rt         = instr_q[20:16];
    assign mem_if.rd         = instr_q[15:11];
    assign mem_if.imm        = instr_q[15:0];
    assign mem_if.pronto     = (estado_q == CONCLUIDO);
    assign mem_if.ocupado    = (estado_q != OCIOSO);
    assign mem_if.erro_alinh = (estado_q == CONCLUIDO) && erro_q;

endmodule

// File: tb/tb_interface_memoria.sv
// Bench for interface_memoria: directed test-plan steps followed by random accesses,
// all checked against a word-level reference model (memory array, MDR, IR).
module tb_interface_memoria;

    localparam int LAT = 2;

    logic clk;
    logic rst_n;

    interface_memoria_if #(.ADDR_W(32)) bus ();

    interface_memoria #(.LAT_LEITURA(LAT), .ADDR_W(32)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .mem_if  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory environment: word array, data valid only in the LAT-th read cycle
    logic [31:0] tb_mem [256];
    int          rd_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_cnt <= 0;
        else        rd_cnt <= bus.mem_rd ? rd_cnt + 1 : 0;
    end

    assign bus.mem_rdata = (bus.mem_rd && rd_cnt == LAT - 1) ? tb_mem[bus.mem_addr[9:2]]
                                                              : 32'hA5A5_5A5A;

    // Reference model state
    logic [31:0] ref_mem [256];
    logic [31:0] ref_mdr;
    logic [31:0] ref_instr;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
        tb_mem[addr[9:2]]  = val;
        ref_mem[addr[9:2]] = val;
    endtask

    task automatic check_regs();
        chk("mdr", bus.mdr, ref_mdr);
        chk("instr", bus.instr, ref_instr);
        chk("opcode", 32'(bus.opcode), 32'(ref_instr[31:26]));
        chk("instr_arit", 32'(bus.instr_arit), 32'(ref_instr[5:0]));
        chk("rs", 32'(bus.rs), 32'(ref_instr[25:21]));
        chk("rt", 32'(bus.rt), 32'(ref_instr[20:16]));
        chk("rd", 32'(bus.rd), 32'(ref_instr[15:11]));
        chk("imm", 32'(bus.imm), 32'(ref_instr[15:0]));
    endtask

    task automatic load_ir();
        @(negedge clk);
        bus.ir_esc = 1'b1;
        @(negedge clk);
        bus.ir_esc = 1'b0;
        ref_instr = ref_mdr;
        check_regs();
    endtask

    // One access: drive req, watch every cycle until pronto, compare with the model
    task automatic do_access(input logic esc, input logic iou, input logic [31:0] pc,
                             input logic [31:0] ula, input logic [31:0] dado,
                             input bit busy, input bit ir_load);
        logic [31:0] a;
        logic [31:0] old_mdr;
        bit          mis;
        bit          err_seen;
        int          exp_lat, rd_n, wr_n, got;
        a        = iou ? ula : pc;
        mis      = (a[1:0] != 2'b00);
        exp_lat  = mis ? 1 : (esc ? 2 : LAT + 1);
        old_mdr  = ref_mdr;
        rd_n     = 0;
        wr_n     = 0;
        got      = 0;
        err_seen = 1'b0;

        @(negedge clk);
        bus.req      = 1'b1;
        bus.esc      = esc;
        bus.iou_d    = iou;
        bus.pc       = pc;
        bus.ula_saida = ula;
        bus.dado_esc = dado;

        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.req    = 1'b0;
            bus.ir_esc = 1'b0;
            if (busy && k == 1) begin
                bus.req   = 1'b1;
                bus.iou_d = ~iou;
                bus.pc    = pc ^ 32'h0000_0200;
                bus.ula_saida = ula ^ 32'h0000_0200;
            end
            chk("ocupado_busy", 32'(bus.ocupado), 32'd1);
            chk("rd_wr_exclusive", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
            if (bus.mem_rd) begin
                rd_n++;
                chk("rd_addr", bus.mem_addr, a);
            end
            if (bus.mem_wr) begin
                wr_n++;
                chk("wr_addr", bus.mem_addr, a);
                chk("wr_data", bus.mem_wdata, dado);
                tb_mem[bus.mem_addr[9:2]] = bus.mem_wdata;
            end
            if (ir_load && !mis && !esc && k == LAT) bus.ir_esc = 1'b1;
            if (bus.pronto) begin
                got      = k;
                err_seen = bus.erro_alinh;
                if (busy) begin
                    bus.req   = 1'b1;
                    bus.iou_d = ~iou;
                end
                break;
            end else begin
                chk("erro_without_pronto", 32'(bus.erro_alinh), 32'd0);
            end
        end

        chk("latency", got, exp_lat);
        chk("erro_alinh", 32'(err_seen), 32'(mis));
        chk("rd_cycles", rd_n, (mis || esc) ? 0 : LAT);
        chk("wr_cycles", wr_n, (!mis && esc) ? 1 : 0);
        chk("addr_latched", bus.mem_addr, a);

        if (!mis && !esc) ref_mdr = ref_mem[a[9:2]];
        if (!mis && esc)  ref_mem[a[9:2]] = dado;
        if (ir_load && !mis && !esc) ref_instr = old_mdr;

        @(negedge clk);
        bus.req = 1'b0;
        chk("pronto_one_cycle", 32'(bus.pronto), 32'd0);
        chk("ocupado_idle", 32'(bus.ocupado), 32'd0);
        check_regs();

        if (busy) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("busy_no_pronto", 32'(bus.pronto), 32'd0);
                chk("busy_no_rd", 32'(bus.mem_rd), 32'd0);
                chk("busy_addr_hold", bus.mem_addr, a);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v, pa, ua;
        rst_n        = 1'b0;
        bus.req      = 1'b0;
        bus.esc      = 1'b0;
        bus.iou_d    = 1'b0;
        bus.pc       = '0;
        bus.ula_saida = '0;
        bus.dado_esc = '0;
        bus.ir_esc   = 1'b0;
        ref_mdr      = '0;
        ref_instr    = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            tb_mem[i]  = v;
            ref_mem[i] = v;
        end
        set_word(32'h0000_0040, 32'h8C22_0004);
        set_word(32'h0000_0080, 32'h0022_1820);

        // Reset state
        #12;
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_flags", {27'd0, bus.mem_rd, bus.mem_wr, bus.pronto, bus.ocupado, bus.erro_alinh}, 32'd0);
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;

        // Read from PC, then load IR and decode an I-type word
        do_access(1'b0, 1'b0, 32'h0000_0040, 32'h0000_0300, 32'h0, 1'b0, 1'b0);
        chk("read_mdr_value", bus.mdr, 32'h8C22_0004);
        load_ir();
        chk("lw_opcode", 32'(bus.opcode), 32'h23);
        chk("lw_rs", 32'(bus.rs), 32'd1);
        chk("lw_rt", 32'(bus.rt), 32'd2);
        chk("lw_imm", 32'(bus.imm), 32'h0004);

        // Write via ULA address; MDR must not move
        do_access(1'b1, 1'b1, 32'h0000_0044, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("write_mdr_unchanged", bus.mdr, 32'h8C22_0004);

        // Misaligned read
        do_access(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0102, 32'h0, 1'b0, 1'b0);

        // Extra requests during LEITURA and CONCLUIDO are dropped
        do_access(1'b0, 1'b0, 32'h0000_0100, 32'h0000_0044, 32'h0, 1'b1, 1'b0);
        chk("readback_write", bus.mdr, 32'hDEAD_BEEF);

        // Reset in the second read cycle
        @(negedge clk);
        bus.req   = 1'b1;
        bus.esc   = 1'b0;
        bus.iou_d = 1'b0;
        bus.pc    = 32'h0000_0040;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        chk("pre_reset_rd", 32'(bus.mem_rd), 32'd1);
        rst_n = 1'b0;
        #1;
        ref_mdr   = '0;
        ref_instr = '0;
        chk("reset_rd_drop", 32'(bus.mem_rd), 32'd0);
        chk("reset_flags", {28'd0, bus.mem_wr, bus.pronto, bus.ocupado, bus.erro_alinh}, 32'd0);
        chk("reset_addr", bus.mem_addr, 32'd0);
        check_regs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_no_pronto", 32'(bus.pronto), 32'd0);
        end
        rst_n = 1'b1;
        do_access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 1'b0);

        // R-type fetch with IR load on the MDR load edge: IR gets the old MDR
        do_access(1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("coincident_ir_old", bus.instr, 32'h8C22_0004);
        load_ir();
        chk("r_opcode", 32'(bus.opcode), 32'd0);
        chk("r_funct", 32'(bus.instr_arit), 32'h20);
        chk("r_rd", 32'(bus.rd), 32'd3);

        // Random mix of reads, writes and misaligned requests
        for (int n = 0; n < 40; n++) begin
            pa = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            ua = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 3) == 0) pa[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) ua[1:0] = 2'($urandom_range(1, 3));
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pa, ua,
                      $urandom, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) load_ir();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
